// File: rtl/pc_pkg.sv
// Shared fetch-stage definitions: RAS pointer/count widths and the RAS checkpoint payload.
package pc_pkg;

    // Depth assumed by pipeline registers that carry RAS checkpoints down to execute
    localparam int unsigned DEFAULT_RAS_DEPTH = 8;

    // Width of the RAS top-of-stack pointer for a given depth (depth is a power of two, >= 2)
    function automatic int unsigned ras_ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Width of the RAS occupancy counter; must represent 0..depth inclusive
    function automatic int unsigned ras_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // True when depth is a power of two, which the circular pointer wrap relies on
    function automatic bit ras_depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    localparam int unsigned CKPT_PTR_W = ras_ptr_w(DEFAULT_RAS_DEPTH);
    localparam int unsigned CKPT_CNT_W = ras_cnt_w(DEFAULT_RAS_DEPTH);

    // RAS state captured alongside each fetched instruction for misprediction recovery
    typedef struct packed {
        logic [CKPT_PTR_W-1:0] ptr;
        logic [CKPT_CNT_W-1:0] cnt;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with push, pop, replace-top and pointer/count restore.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic                                pop,
    input  logic                                replace,
    input  logic                                restore,
    input  logic [XLEN-1:0]                     wdata,
    input  logic [ras_ptr_w(RAS_DEPTH)-1:0]     restore_ptr,
    input  logic [ras_cnt_w(RAS_DEPTH)-1:0]     restore_cnt,
    output logic [XLEN-1:0]                     top_c,
    output logic [ras_ptr_w(RAS_DEPTH)-1:0]     ptr,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0]     cnt
);

    localparam int unsigned PTR_W = ras_ptr_w(RAS_DEPTH);
    localparam int unsigned CNT_W = ras_cnt_w(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    // Next pointer/count and write port; restore dominates, then push, replace, pop
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (restore) begin
            ptr_d = restore_ptr;
            cnt_d = restore_cnt;
        end else if (push) begin
            // Pointer wraps naturally; on overflow the oldest entry is overwritten
            ptr_d  = ptr_q + PTR_W'(1);
            wr_en  = 1'b1;
            wr_idx = ptr_q + PTR_W'(1);
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (replace) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage; cleared on reset, written at most one entry per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wdata;
        end
    end

    // Same-cycle top-of-stack read; no bypass of a write landing at this edge
    assign top_c = mem[ptr_q];
    assign ptr   = ptr_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator: next-PC priority select, RAS action qualification and the PC register.
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     FETCH_BYTES  = 4,
    parameter int unsigned     RAS_DEPTH    = 8
) (
    input  logic                                iClk,
    input  logic                                iRstN,
    input  logic                                iStallF,
    input  logic                                iPredTakenF,
    input  logic [XLEN-1:0]                     iPredTargetF,
    input  logic                                iIsCallF,
    input  logic                                iIsRetF,
    input  logic                                iRedirectD,
    input  logic [XLEN-1:0]                     iRedirectTargetD,
    input  logic                                iRecoverE,
    input  logic [XLEN-1:0]                     iRecoverTargetE,
    input  logic [ras_ptr_w(RAS_DEPTH)-1:0]     iRecoverPtrE,
    input  logic [ras_cnt_w(RAS_DEPTH)-1:0]     iRecoverCntE,
    output logic [XLEN-1:0]                     oPC,
    output logic [ras_ptr_w(RAS_DEPTH)-1:0]     oRasPtrF,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0]     oRasCntF
);

    localparam int unsigned PTR_W = ras_ptr_w(RAS_DEPTH);
    localparam int unsigned CNT_W = ras_cnt_w(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  ras_top;
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_nonempty;
    logic             fetch_act;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_replace;

    // Sequential PC doubles as the return address pushed by a call
    assign seq_pc       = pc_q + XLEN'(FETCH_BYTES);
    assign ras_nonempty = (ras_cnt != '0);

    // RAS acts only on cycles where fetch proceeds down its own predicted path
    always_comb begin
        fetch_act   = !iStallF && !iRecoverE && !iRedirectD;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;
        if (fetch_act) begin
            if (iIsCallF && iIsRetF && ras_nonempty) begin
                ras_replace = 1'b1;
            end else if (iIsCallF) begin
                ras_push = 1'b1;
            end else if (iIsRetF && ras_nonempty) begin
                ras_pop = 1'b1;
            end
        end
    end

    // Next-PC priority: recovery, stall, decode redirect, RAS return, predicted taken, sequential
    always_comb begin
        pc_d = seq_pc;
        if (iRecoverE) begin
            pc_d = iRecoverTargetE;
        end else if (iStallF) begin
            pc_d = pc_q;
        end else if (iRedirectD) begin
            pc_d = iRedirectTargetD;
        end else if (iIsRetF && ras_nonempty) begin
            pc_d = ras_top;
        end else if (iPredTakenF) begin
            pc_d = iPredTargetF;
        end
    end

    // Fetch PC register
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (iClk),
        .rst_n       (iRstN),
        .push        (ras_push),
        .pop         (ras_pop),
        .replace     (ras_replace),
        .restore     (iRecoverE),
        .wdata       (seq_pc),
        .restore_ptr (iRecoverPtrE),
        .restore_cnt (iRecoverCntE),
        .top_c       (ras_top),
        .ptr         (ras_ptr),
        .cnt         (ras_cnt)
    );

    assign oPC      = pc_q;
    assign oRasPtrF = ras_ptr;
    assign oRasCntF = ras_cnt;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: sequential fetch, RAS call/return, overflow, stall, recovery, reset.
module tb_pc_gen_ras;

    logic        iClk;
    logic        iRstN;
    logic        iStallF;
    logic        iPredTakenF;
    logic [31:0] iPredTargetF;
    logic        iIsCallF;
    logic        iIsRetF;
    logic        iRedirectD;
    logic [31:0] iRedirectTargetD;
    logic        iRecoverE;
    logic [31:0] iRecoverTargetE;
    logic [2:0]  iRecoverPtrE;
    logic [3:0]  iRecoverCntE;
    logic [31:0] oPC;
    logic [2:0]  oRasPtrF;
    logic [3:0]  oRasCntF;

    int vectors;
    int miscompares;

    pc_gen_ras #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .FETCH_BYTES  (4),
        .RAS_DEPTH    (8)
    ) dut (
        .iClk             (iClk),
        .iRstN            (iRstN),
        .iStallF          (iStallF),
        .iPredTakenF      (iPredTakenF),
        .iPredTargetF     (iPredTargetF),
        .iIsCallF         (iIsCallF),
        .iIsRetF          (iIsRetF),
        .iRedirectD       (iRedirectD),
        .iRedirectTargetD (iRedirectTargetD),
        .iRecoverE        (iRecoverE),
        .iRecoverTargetE  (iRecoverTargetE),
        .iRecoverPtrE     (iRecoverPtrE),
        .iRecoverCntE     (iRecoverCntE),
        .oPC              (oPC),
        .oRasPtrF         (oRasPtrF),
        .oRasCntF         (oRasCntF)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic clear_ctl();
        iStallF          = 1'b0;
        iPredTakenF      = 1'b0;
        iPredTargetF     = '0;
        iIsCallF         = 1'b0;
        iIsRetF          = 1'b0;
        iRedirectD       = 1'b0;
        iRedirectTargetD = '0;
        iRecoverE        = 1'b0;
        iRecoverTargetE  = '0;
        iRecoverPtrE     = '0;
        iRecoverCntE     = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_ctl();
        iRstN = 1'b0;

        // reset state
        #3;
        check("rst_pc", 64'(oPC), 64'h0);
        check("rst_ptr", 64'(oRasPtrF), 64'h0);
        check("rst_cnt", 64'(oRasCntF), 64'h0);
        @(posedge iClk);
        #1;
        iRstN = 1'b1;
        check("seq_pc0", 64'(oPC), 64'h0);
        tick();
        check("seq_pc1", 64'(oPC), 64'h4);
        tick();
        check("seq_pc2", 64'(oPC), 64'h8);
        tick();
        check("seq_pc3", 64'(oPC), 64'hC);
        check("seq_cnt", 64'(oRasCntF), 64'h0);

        // simple call at 0x100 then return at 0x200
        iRedirectD = 1'b1; iRedirectTargetD = 32'h100;
        tick();
        clear_ctl();
        check("redir_pc", 64'(oPC), 64'h100);
        check("redir_cnt", 64'(oRasCntF), 64'h0);
        iIsCallF = 1'b1; iPredTakenF = 1'b1; iPredTargetF = 32'h200;
        tick();
        clear_ctl();
        check("call_pc", 64'(oPC), 64'h200);
        check("call_cnt", 64'(oRasCntF), 64'h1);
        check("call_ptr", 64'(oRasPtrF), 64'h1);
        iIsRetF = 1'b1;
        tick();
        clear_ctl();
        check("ret_pc", 64'(oPC), 64'h104);
        check("ret_cnt", 64'(oRasCntF), 64'h0);
        check("ret_ptr", 64'(oRasPtrF), 64'h0);

        // nine nested calls overflow an 8-deep stack
        iRedirectD = 1'b1; iRedirectTargetD = 32'h1000;
        tick();
        clear_ctl();
        for (int k = 0; k < 9; k++) begin
            check("nest_pc", 64'(oPC), 64'(32'h1000 + 32'(16 * k)));
            iIsCallF = 1'b1; iPredTakenF = 1'b1;
            iPredTargetF = 32'h1000 + 32'(16 * (k + 1));
            tick();
        end
        clear_ctl();
        check("nest_pc_end", 64'(oPC), 64'h1090);
        check("nest_cnt_sat", 64'(oRasCntF), 64'h8);
        check("nest_ptr_wrap", 64'(oRasPtrF), 64'h1);
        iIsRetF = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            check("unwind_pc", 64'(oPC), 64'(32'h1084 - 32'(16 * j)));
            check("unwind_cnt", 64'(oRasCntF), 64'(7 - j));
        end
        tick();
        check("empty_ret_pc", 64'(oPC), 64'h1018);
        check("empty_ret_cnt", 64'(oRasCntF), 64'h0);
        check("empty_ret_ptr", 64'(oRasPtrF), 64'h1);
        clear_ctl();

        // stall holds everything, even with a call present
        iStallF = 1'b1; iIsCallF = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_pc", 64'(oPC), 64'h1018);
            check("stall_ptr", 64'(oRasPtrF), 64'h1);
            check("stall_cnt", 64'(oRasCntF), 64'h0);
        end
        iRecoverE = 1'b1; iRecoverTargetE = 32'h400; iRecoverPtrE = 3'd2; iRecoverCntE = 4'd3;
        tick();
        clear_ctl();
        check("rec_stall_pc", 64'(oPC), 64'h400);
        check("rec_stall_ptr", 64'(oRasPtrF), 64'h2);
        check("rec_stall_cnt", 64'(oRasCntF), 64'h3);

        // decode redirect beats return and leaves the RAS alone
        iRecoverE = 1'b1; iRecoverTargetE = 32'h500; iRecoverPtrE = 3'd5; iRecoverCntE = 4'd2;
        tick();
        clear_ctl();
        check("rec2_cnt", 64'(oRasCntF), 64'h2);
        iRedirectD = 1'b1; iRedirectTargetD = 32'h800; iIsRetF = 1'b1;
        tick();
        clear_ctl();
        check("redir_ret_pc", 64'(oPC), 64'h800);
        check("redir_ret_cnt", 64'(oRasCntF), 64'h2);
        check("redir_ret_ptr", 64'(oRasPtrF), 64'h5);
        iRecoverE = 1'b1; iRecoverTargetE = 32'h900; iRecoverPtrE = 3'd0; iRecoverCntE = 4'd0;
        iRedirectD = 1'b1; iRedirectTargetD = 32'hA00;
        tick();
        clear_ctl();
        check("rec_vs_redir_pc", 64'(oPC), 64'h900);
        check("rec_vs_redir_cnt", 64'(oRasCntF), 64'h0);

        // call and return together replace the top entry
        iRedirectD = 1'b1; iRedirectTargetD = 32'h4C;
        tick();
        clear_ctl();
        iIsCallF = 1'b1; iPredTakenF = 1'b1; iPredTargetF = 32'h60;
        tick();
        clear_ctl();
        check("push50_pc", 64'(oPC), 64'h60);
        check("push50_cnt", 64'(oRasCntF), 64'h1);
        iRedirectD = 1'b1; iRedirectTargetD = 32'h300;
        tick();
        clear_ctl();
        check("at300_pc", 64'(oPC), 64'h300);
        iIsCallF = 1'b1; iIsRetF = 1'b1;
        tick();
        clear_ctl();
        check("callret_pc", 64'(oPC), 64'h50);
        check("callret_cnt", 64'(oRasCntF), 64'h1);
        check("callret_ptr", 64'(oRasPtrF), 64'h1);
        iIsRetF = 1'b1;
        tick();
        clear_ctl();
        check("replaced_top_pc", 64'(oPC), 64'h304);
        check("replaced_top_cnt", 64'(oRasCntF), 64'h0);

        // call and return with empty stack behave as a call
        iIsCallF = 1'b1; iIsRetF = 1'b1;
        tick();
        clear_ctl();
        check("callret_empty_pc", 64'(oPC), 64'h308);
        check("callret_empty_cnt", 64'(oRasCntF), 64'h1);
        check("callret_empty_ptr", 64'(oRasPtrF), 64'h1);

        // PC wraps modulo 2^32
        iRedirectD = 1'b1; iRedirectTargetD = 32'hFFFF_FFFC;
        tick();
        clear_ctl();
        check("wrap_pre", 64'(oPC), 64'hFFFF_FFFC);
        tick();
        check("wrap_pc", 64'(oPC), 64'h0);

        // asynchronous reset mid-sequence
        #3;
        iRstN = 1'b0;
        #1;
        check("async_rst_pc", 64'(oPC), 64'h0);
        check("async_rst_ptr", 64'(oRasPtrF), 64'h0);
        check("async_rst_cnt", 64'(oRasCntF), 64'h0);
        #2;
        iRstN = 1'b1;
        tick();
        check("post_rst_pc", 64'(oPC), 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_gen_ras.md
# pc_gen_ras

Parametrised fetch-stage PC generator with an integrated return-address stack (RAS); the next generation of the fetch PC register. Each cycle it selects the next fetch PC from execute-stage recovery, decode-stage redirect, RAS-predicted return, fetch-predicted branch target or sequential PC. It also maintains a circular RAS with overflow wrap and pointer checkpoint/restore for misprediction recovery. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
- XLEN, 32, PC and target width
- RESET_VECTOR, 0, oPC value after reset
- FETCH_BYTES, 4, sequential increment and return-address offset
- RAS_DEPTH, 8, RAS entries; power of two, ≥2
- iClk  in  1  clock, rising edge
- iRstN  in  1  asynchronous, active-low reset
- iStallF  in  1  hold PC and RAS; overridden by iRecoverE only
- iPredTakenF  in  1  fetch predictor says taken
- iPredTargetF  in  XLEN  predicted branch target
- iIsCallF  in  1  instruction at oPC is a call
- iIsRetF  in  1  instruction at oPC is a return
- iRedirectD  in  1  decode-stage redirect
- iRedirectTargetD  in  XLEN  decode redirect target
- iRecoverE  in  1  execute-stage misprediction recovery
- iRecoverTargetE  in  XLEN  correct PC
- iRecoverPtrE  in  $clog2(RAS_DEPTH)  RAS top pointer to restore
- iRecoverCntE  in  $clog2(RAS_DEPTH+1)  RAS occupancy to restore
- oPC  out  XLEN  current fetch PC
- oRasPtrF  out  $clog2(RAS_DEPTH)  RAS top pointer before oPC's instruction acts (checkpoint)
- oRasCntF  out  $clog2(RAS_DEPTH+1)  RAS occupancy before oPC's instruction acts (checkpoint)

## Operation
- Next-PC priority: iRecoverE → iRecoverTargetE; else iStallF → hold; else iRedirectD → iRedirectTargetD; else iIsRetF && cnt>0 → stack[ptr]; else iPredTakenF → iPredTargetF; else oPC+FETCH_BYTES.
- PC arithmetic is modulo 2^XLEN and wraps silently. Targets are used unmodified, with no alignment masking.
- RAS actions happen only when the cycle is not stalled, not recovering and not redirected (the "fetch-act" condition):
  - Call only: ptr←ptr+1 (mod RAS_DEPTH); stack[ptr+1]←oPC+FETCH_BYTES; cnt←min(cnt+1,RAS_DEPTH). Overflow overwrites the oldest entry.
  - Return only, cnt>0: ptr←ptr−1; cnt←cnt−1.
  - Return only, cnt==0: no RAS change. Next PC falls through to iPredTakenF or sequential.
  - Call and return together, cnt>0: next PC = stack[ptr]; stack[ptr]←oPC+FETCH_BYTES; ptr and cnt unchanged.
  - Call and return together, cnt==0: treated as call only.
- Recovery: ptr←iRecoverPtrE; cnt←iRecoverCntE. Stack contents are not restored; entries overwritten on the wrong path stay corrupted, and this is accepted.
- iRedirectD with no stall: RAS unchanged. Decode is responsible for its own RAS fix-ups via a later recovery.

## Timing
- Reset (iRstN low, asynchronous): oPC=RESET_VECTOR, ptr=0, cnt=0, all stack entries 0. Release is synchronous to the next iClk edge.
- Next-PC select is combinational from inputs and state. oPC, ptr, cnt and stack update on the rising iClk edge, giving one-cycle latency from input to oPC.
- oRasPtrF and oRasCntF are the registered state values with no combinational path from inputs.
- RAS read (stack[ptr]) is combinational and same-cycle. The write takes effect at the edge; there is no read-after-write bypass within a cycle.
- Reset asserted mid-operation aborts any pending update. Reset wins over all other inputs.

## Structure
- Shared package pc_pkg: RAS pointer and count width functions, and typedef ras_ckpt_t {ptr, cnt}. Pipeline registers carry ras_ckpt_t down to execute.
- Sub-module ras_stack holds the circular buffer, ptr and cnt, with push, pop, replace and restore controls. It also provides the top-of-stack read and the checkpoint outputs.
- The top level contains the next-PC priority mux, the fetch-act qualification, and the oPC register.

## Test plan
- Reset then 3 unstalled cycles, no control inputs → oPC 0x0, 0x4, 0x8, 0xC; oRasCntF=0.
- Call at 0x100, then return at 0x200 (iPredTakenF to 0x200 on the call) → PC after the return is 0x104; cnt goes 0→1→0.
- RAS_DEPTH=8, 9 nested calls at PCs 0x1000+16k → cnt saturates at 8. Nine returns yield 0x1084 down to 0x1014. The ninth return falls through to sequential.
- iStallF held with iIsCallF for 3 cycles → oPC, ptr and cnt are unchanged. iRecoverE during the stall with target 0x400, ptr 2, cnt 3 → next oPC=0x400, oRasPtrF=2, oRasCntF=3.
- iRedirectD (target 0x800) with iIsRetF and cnt=2 in the same cycle → oPC=0x800, cnt stays 2. iRecoverE together with iRedirectD → recovery target wins.
- Call and return together at 0x300 with stack top 0x50 → next PC 0x50, top becomes 0x304, cnt unchanged. Assert iRstN low asynchronously mid-sequence → oPC=RESET_VECTOR immediately.
